// File: rtl/demux_deserializer.sv
// rtl/demux_deserializer.sv - serial-to-parallel lane demultiplexer with valid/ready on both sides
// Rebuilds NUM_OUTPUTS-bit words from an LSB-first bit stream steered by a lane counter.
module demux_deserializer #(
  parameter int NUM_OUTPUTS = 8,
  parameter int IDX_W       = $clog2(NUM_OUTPUTS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   din,
  input  logic                   din_valid,
  output logic                   din_ready,
  input  logic                   clear,
  output logic [IDX_W-1:0]       sel_idx,
  output logic [NUM_OUTPUTS-1:0] dout,
  output logic                   dout_valid,
  input  logic                   dout_ready
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OUTPUTS - 1);

  logic [IDX_W-1:0]       r_idx;
  logic [NUM_OUTPUTS-2:0] r_asm;
  logic [NUM_OUTPUTS-1:0] r_dout;
  logic                   r_dout_valid;

  logic w_last;
  logic w_ready;
  logic w_accept;
  logic w_complete;

  // Only the final bit of a word can stall: it needs the output register free.
  assign w_last     = (r_idx == LAST_IDX);
  assign w_ready    = !(w_last && r_dout_valid && !dout_ready) && !clear;
  assign w_accept   = din_valid && w_ready;
  assign w_complete = w_accept && w_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= '0;
      r_asm <= '0;
    end else if (clear) begin
      r_idx <= '0;
      r_asm <= '0;
    end else if (w_accept) begin
      if (w_last) begin
        r_idx <= '0;
      end else begin
        r_idx        <= r_idx + IDX_W'(1);
        r_asm[r_idx] <= din;
      end
    end
  end

  // A completion in the same cycle as a consume reloads without a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
    end else if (w_complete) begin
      r_dout       <= {din, r_asm};
      r_dout_valid <= 1'b1;
    end else if (dout_ready) begin
      r_dout_valid <= 1'b0;
    end
  end

  assign din_ready  = w_ready;
  assign sel_idx    = r_idx;
  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;

endmodule

// File: tb/tb_demux_deserializer.sv
// tb/tb_demux_deserializer.sv - directed self-checking bench for demux_deserializer
module tb_demux_deserializer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       din;
  logic       din_valid;
  logic       din_ready;
  logic       clear;
  logic [2:0] sel_idx;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;

  int checks = 0;
  int errors = 0;

  demux_deserializer #(.NUM_OUTPUTS(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .clear      (clear),
    .sel_idx    (sel_idx),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; registered outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    din_valid = 1'b1;
    din       = b;
    tick();
    din_valid = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 0; i < 8; i++) send_bit(w[i]);
  endtask

  logic [7:0] pat;

  initial begin
    rst_n = 1'b0; din = 1'b0; din_valid = 1'b0; clear = 1'b0; dout_ready = 1'b0;

    // Reset
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("rst_dout", dout, 32'h00);
    chk("rst_valid", dout_valid, 0);
    chk("rst_din_ready", din_ready, 1);
    chk("rst_sel", sel_idx, 0);

    // Single word 1,0,1,1,0,0,1,0 -> 0x4D
    dout_ready = 1'b1;
    pat = 8'h4D;
    for (int i = 0; i < 8; i++) begin
      chk("single_sel", sel_idx, i);
      send_bit(pat[i]);
    end
    chk("single_dout", dout, 32'h4D);
    chk("single_valid", dout_valid, 1);
    chk("single_sel_wrap", sel_idx, 0);
    tick();
    chk("single_valid_pulse", dout_valid, 0);

    // Back-to-back 0xA5 then 0x3C
    for (int k = 0; k < 16; k++) begin
      pat = (k < 8) ? 8'hA5 : 8'h3C;
      din_valid = 1'b1;
      din = pat[k % 8];
      #1;
      chk("b2b_din_ready", din_ready, 1);
      @(posedge clk);
      #1;
      chk("b2b_valid", dout_valid, (k == 7 || k == 15) ? 1 : 0);
      if (k == 7)  chk("b2b_dout_a5", dout, 32'hA5);
      if (k == 15) chk("b2b_dout_3c", dout, 32'h3C);
    end
    din_valid = 1'b0;
    tick();

    // Backpressure
    dout_ready = 1'b0;
    send_word(8'hA5);
    chk("bp_dout_a5", dout, 32'hA5);
    chk("bp_valid", dout_valid, 1);
    pat = 8'h3C;
    for (int i = 0; i < 7; i++) begin
      din_valid = 1'b1;
      din = pat[i];
      #1;
      chk("bp_accept_ready", din_ready, 1);
      @(posedge clk);
      #1;
    end
    chk("bp_sel7", sel_idx, 7);
    din_valid = 1'b1;
    din = pat[7];
    #1;
    chk("bp_stall_ready", din_ready, 0);
    tick();
    chk("bp_stall_sel", sel_idx, 7);
    chk("bp_hold_dout", dout, 32'hA5);
    dout_ready = 1'b1;
    #1;
    chk("bp_release_ready", din_ready, 1);
    tick();
    din_valid = 1'b0;
    dout_ready = 1'b0;
    chk("bp_dout_3c", dout, 32'h3C);
    chk("bp_valid_no_bubble", dout_valid, 1);
    chk("bp_sel_wrap", sel_idx, 0);
    tick();
    chk("bp_valid_held", dout_valid, 1);
    dout_ready = 1'b1;
    tick();
    chk("bp_drained", dout_valid, 0);

    // Clear
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    chk("clr_sel3", sel_idx, 3);
    clear = 1'b1;
    din_valid = 1'b1;
    din = 1'b1;
    #1;
    chk("clr_din_ready", din_ready, 0);
    tick();
    clear = 1'b0;
    din_valid = 1'b0;
    chk("clr_sel0", sel_idx, 0);
    chk("clr_valid_untouched", dout_valid, 0);
    send_word(8'h00);
    chk("clr_dout", dout, 32'h00);
    chk("clr_valid", dout_valid, 1);
    tick();

    // Async reset mid-operation
    dout_ready = 1'b0;
    send_word(8'hA5);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    chk("ar_pre_valid", dout_valid, 1);
    chk("ar_pre_dout", dout, 32'hA5);
    chk("ar_pre_sel", sel_idx, 5);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_dout", dout, 32'h00);
    chk("ar_valid", dout_valid, 0);
    chk("ar_sel", sel_idx, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("ar_after_sel", sel_idx, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
